regfile_scoreboard: RTL and testbench

- Issue-stage hazard controller for the 32x32 register file of the pipelined MIPS core.
- Tracks which architectural registers have an in-flight writer. Stalls issue on RAW and WAW hazards and on a full outstanding-writer budget.
- Clears pending entries on writeback and counts stall cycles for performance monitoring.
- Sits between decode/issue and the register file write-back path. Register 0 is never tracked.

---
 rtl/regfile_scoreboard.sv | 122 ++++++++++++
 tb/tb_regfile_scoreboard.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Issue-stage hazard controller for the 32x32 register file.
//               Tracks which architectural registers have an in-flight writer
//               and stalls issue on RAW, WAW and a full writer budget. Pending
//               entries are cleared on writeback. Stall cycles are counted for
//               performance monitoring. Register 0 is never tracked.
// Ports       :
//   clk_i            system clock, rising edge
//   reset_i          synchronous active-high reset
//   issue_valid_i    decode presents an instruction
//   issue_rs_i/_use  source register A and its read enable
//   issue_rt_i/_use  source register B and its read enable
//   issue_wr_i       instruction writes issue_rd_i
//   issue_rd_i       destination register
//   issue_ready_o    instruction accepted this cycle (combinational)
//   wb_valid_i       writeback to wb_rd_i this cycle
//   wb_rd_i          writeback destination
//   flush_i          discard all in-flight writers
//   pending_mask_o   bit n set = register n has an outstanding writer
//   outstanding_o    population count of pending_mask_o
//   stall_cycles_o   saturating count of stalled issue cycles
//   wb_error_o       sticky: writeback to a non-pending nonzero register
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
  parameter int MAX_OUTSTANDING = 8,
  parameter int CNT_W           = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             issue_valid_i,
  input  logic [4:0]       issue_rs_i,
  input  logic             issue_use_rs_i,
  input  logic [4:0]       issue_rt_i,
  input  logic             issue_use_rt_i,
  input  logic             issue_wr_i,
  input  logic [4:0]       issue_rd_i,
  output logic             issue_ready_o,
  input  logic             wb_valid_i,
  input  logic [4:0]       wb_rd_i,
  input  logic             flush_i,
  output logic [31:0]      pending_mask_o,
  output logic [5:0]       outstanding_o,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic             wb_error_o
);

  localparam logic [5:0]       C_MAX_OUT = 6'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  logic [31:0]      pending_q, pending_d;
  logic [5:0]       outstanding_q, outstanding_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             wb_error_q, wb_error_d;

  logic w_raw, w_waw, w_full, w_ready;
  logic w_set, w_clr, w_err, w_stall;

  // Hazards look only at the registered mask: a writeback in the same cycle
  // is not bypassed, since the register file write has not landed yet.
  always_comb begin
    w_raw   = (issue_use_rs_i & pending_q[issue_rs_i]) |
              (issue_use_rt_i & pending_q[issue_rt_i]);
    w_waw   = issue_wr_i & (issue_rd_i != 5'd0) & pending_q[issue_rd_i];
    w_full  = issue_wr_i & (issue_rd_i != 5'd0) & (outstanding_q == C_MAX_OUT);
    w_ready = issue_valid_i & ~w_raw & ~w_waw & ~w_full & ~flush_i & ~reset_i;
  end

  assign issue_ready_o = w_ready;

  always_comb begin
    w_set   = w_ready & issue_wr_i & (issue_rd_i != 5'd0);
    w_clr   = wb_valid_i & (wb_rd_i != 5'd0) &  pending_q[wb_rd_i];
    w_err   = wb_valid_i & (wb_rd_i != 5'd0) & ~pending_q[wb_rd_i];
    w_stall = issue_valid_i & ~w_ready & ~flush_i;

    pending_d     = pending_q;
    outstanding_d = outstanding_q;
    wb_error_d    = wb_error_q;
    stall_d       = stall_q;

    if (flush_i) begin
      // Flush wins over a same-cycle set and clear; the writeback is dropped.
      pending_d     = 32'd0;
      outstanding_d = 6'd0;
    end else begin
      // Set and clear can never target the same register (set needs it idle,
      // clear needs it pending), so applying both in sequence is safe.
      if (w_set) pending_d[issue_rd_i] = 1'b1;
      if (w_clr) pending_d[wb_rd_i]    = 1'b0;
      outstanding_d = outstanding_q + 6'(w_set) - 6'(w_clr);
      wb_error_d    = wb_error_q | w_err;
    end

    if (w_stall && (stall_q != C_CNT_MAX)) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pending_q     <= 32'd0;
      outstanding_q <= 6'd0;
      stall_q       <= '0;
      wb_error_q    <= 1'b0;
    end else begin
      pending_q     <= {pending_d[31:1], 1'b0};
      outstanding_q <= outstanding_d;
      stall_q       <= stall_d;
      wb_error_q    <= wb_error_d;
    end
  end

  assign pending_mask_o = pending_q;
  assign outstanding_o  = outstanding_q;
  assign stall_cycles_o = stall_q;
  assign wb_error_o     = wb_error_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_scoreboard
// Description : Self-checking bench for regfile_scoreboard. A behavioural
//               model (array of pending flags, integer counters) predicts all
//               outputs every cycle; directed scenarios pin known values and a
//               randomized phase exercises hazards, flushes and resets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;

  localparam int MAXO  = 2;
  localparam int CNT_W = 5;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic             issue_valid, issue_use_rs, issue_use_rt, issue_wr;
  logic [4:0]       issue_rs, issue_rt, issue_rd;
  logic             issue_ready;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic             flush;
  logic [31:0]      pending_mask;
  logic [5:0]       outstanding;
  logic [CNT_W-1:0] stall_cycles;
  logic             wb_error;

  regfile_scoreboard #(
    .MAX_OUTSTANDING(MAXO),
    .CNT_W          (CNT_W)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .issue_valid_i (issue_valid),
    .issue_rs_i    (issue_rs),
    .issue_use_rs_i(issue_use_rs),
    .issue_rt_i    (issue_rt),
    .issue_use_rt_i(issue_use_rt),
    .issue_wr_i    (issue_wr),
    .issue_rd_i    (issue_rd),
    .issue_ready_o (issue_ready),
    .wb_valid_i    (wb_valid),
    .wb_rd_i       (wb_rd),
    .flush_i       (flush),
    .pending_mask_o(pending_mask),
    .outstanding_o (outstanding),
    .stall_cycles_o(stall_cycles),
    .wb_error_o    (wb_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  // ---------------- behavioural model ----------------
  bit m_pend [32];
  int m_stall;
  bit m_err;

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < 32; i++) if (m_pend[i]) c++;
    return c;
  endfunction

  function automatic logic [31:0] m_mask();
    logic [31:0] m = '0;
    for (int i = 0; i < 32; i++) m[i] = m_pend[i];
    return m;
  endfunction

  function automatic bit m_ready();
    bit raw, waw, full;
    raw  = (issue_use_rs && m_pend[issue_rs]) || (issue_use_rt && m_pend[issue_rt]);
    waw  = issue_wr && issue_rd != 0 && m_pend[issue_rd];
    full = issue_wr && issue_rd != 0 && m_count() == MAXO;
    return issue_valid && !raw && !waw && !full && !flush && !reset;
  endfunction

  always @(posedge clk) begin
    bit r;
    r = m_ready();
    if (reset) begin
      for (int i = 0; i < 32; i++) m_pend[i] = 0;
      m_stall = 0;
      m_err   = 0;
    end else begin
      if (issue_valid && !r && !flush) m_stall = (m_stall == CMAX) ? CMAX : m_stall + 1;
      if (flush) begin
        for (int i = 0; i < 32; i++) m_pend[i] = 0;
      end else begin
        if (wb_valid && wb_rd != 0) begin
          if (m_pend[wb_rd]) m_pend[wb_rd] = 0;
          else               m_err = 1;
        end
        if (r && issue_wr && issue_rd != 0) m_pend[issue_rd] = 1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: checks every output against the model mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready",       64'(issue_ready),  64'(m_ready()));
      chk("mask",        64'(pending_mask), 64'(m_mask()));
      chk("outstanding", 64'(outstanding),  64'(m_count()));
      chk("stall",       64'(stall_cycles), 64'(m_stall));
      chk("wb_error",    64'(wb_error),     64'(m_err));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit v, input int rs, input bit urs, input int rt, input bit urt,
                     input bit wr, input int rd, input bit wbv, input int wbr, input bit fl);
    issue_valid  = v;
    issue_rs     = 5'(rs);
    issue_use_rs = urs;
    issue_rt     = 5'(rt);
    issue_use_rt = urt;
    issue_wr     = wr;
    issue_rd     = 5'(rd);
    wb_valid     = wbv;
    wb_rd        = 5'(wbr);
    flush        = fl;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rnd_inputs();
    issue_valid  = ($urandom_range(0, 3) != 0);
    issue_rs     = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    issue_rt     = 5'($urandom_range(0, 7));
    issue_rd     = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    issue_use_rs = 1'($urandom_range(0, 1));
    issue_use_rt = 1'($urandom_range(0, 1));
    issue_wr     = 1'($urandom_range(0, 1));
    wb_valid     = ($urandom_range(0, 2) == 0);
    wb_rd        = 5'($urandom_range(0, 7));
    flush        = ($urandom_range(0, 29) == 0);
  endtask

  initial begin
    reset = 1'b1;
    idle();

    // Reset with random inputs: ready stays low, state clears.
    rnd_inputs();
    #1 chk("rst_ready0", 64'(issue_ready), 64'd0);
    step();
    chk_en = 1;
    rnd_inputs();
    #1 chk("rst_ready1", 64'(issue_ready), 64'd0);
    chk("rst_mask", 64'(pending_mask), 64'd0);
    chk("rst_out",  64'(outstanding),  64'd0);
    chk("rst_stall", 64'(stall_cycles), 64'd0);
    chk("rst_err",  64'(wb_error),     64'd0);
    step();
    reset = 1'b0;
    idle();

    // RAW on r5, no bypass from same-cycle writeback.
    drv(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
    #1 chk("raw_issue_ready", 64'(issue_ready), 64'd1);
    step();
    chk("raw_mask5", 64'(pending_mask), 64'h20);
    drv(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("raw_stall_ready", 64'(issue_ready), 64'd0);
    step();
    chk("raw_stall1", 64'(stall_cycles), 64'd1);
    step();
    chk("raw_stall2", 64'(stall_cycles), 64'd2);
    drv(1, 5, 1, 0, 0, 0, 0, 1, 5, 0);
    #1 chk("raw_nobypass", 64'(issue_ready), 64'd0);
    step();
    drv(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("raw_freed_ready", 64'(issue_ready), 64'd1);
    chk("raw_freed_mask", 64'(pending_mask), 64'd0);
    chk("raw_stall3", 64'(stall_cycles), 64'd3);
    step();

    // Same-cycle writeback of r7 does not release a reader of r7.
    drv(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
    step();
    drv(1, 7, 1, 0, 0, 0, 0, 1, 7, 0);
    #1 chk("r7_same_cycle", 64'(issue_ready), 64'd0);
    step();
    drv(1, 7, 1, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("r7_next_cycle", 64'(issue_ready), 64'd1);
    step();

    // WAW and full with a budget of 2.
    drv(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    step();
    drv(1, 0, 0, 0, 0, 1, 4, 0, 0, 0);
    step();
    chk("full_out2", 64'(outstanding), 64'd2);
    drv(1, 0, 0, 0, 0, 1, 9, 0, 0, 0);
    #1 chk("full_stall", 64'(issue_ready), 64'd0);
    drv(1, 1, 1, 2, 1, 0, 0, 0, 0, 0);
    #1 chk("full_nonwriter", 64'(issue_ready), 64'd1);
    drv(1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
    #1 chk("waw_stall", 64'(issue_ready), 64'd0);
    step();
    drv(1, 0, 0, 0, 0, 1, 9, 1, 3, 0);
    #1 chk("full_wb_nobypass", 64'(issue_ready), 64'd0);
    step();
    drv(1, 0, 0, 0, 0, 1, 9, 0, 0, 0);
    #1 chk("full_freed", 64'(issue_ready), 64'd1);
    step();
    chk("full_mask", 64'(pending_mask), 64'h210);

    // Register 0 and the sticky error.
    drv(0, 0, 0, 0, 0, 0, 0, 1, 4, 0);
    step();
    drv(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
    step();
    drv(1, 0, 1, 0, 1, 1, 0, 0, 0, 0);
    #1 chk("r0_ready", 64'(issue_ready), 64'd1);
    step();
    chk("r0_mask", 64'(pending_mask), 64'd0);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step();
    chk("wb0_noerr", 64'(wb_error), 64'd0);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 12, 0);
    step();
    idle();
    chk("wb12_err", 64'(wb_error), 64'd1);
    step();
    step();
    chk("err_sticky", 64'(wb_error), 64'd1);

    // Flush beats a same-cycle set and clear.
    drv(1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    step();
    drv(1, 0, 0, 0, 0, 1, 6, 0, 0, 0);
    step();
    chk("fl_mask_pre", 64'(pending_mask), 64'h44);
    drv(1, 0, 0, 0, 0, 1, 8, 1, 2, 1);
    #1 chk("fl_ready", 64'(issue_ready), 64'd0);
    step();
    idle();
    chk("fl_mask", 64'(pending_mask), 64'd0);
    chk("fl_out",  64'(outstanding),  64'd0);
    chk("fl_err",  64'(wb_error),     64'd1);

    // Saturate the stall counter.
    drv(1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    step();
    drv(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) step();
    chk("stall_sat", 64'(stall_cycles), 64'(CMAX));
    step();
    chk("stall_hold", 64'(stall_cycles), 64'(CMAX));

    // Randomized phase with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 149) == 0);
      rnd_inputs();
      step();
    end
    reset = 1'b0;
    idle();
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
